iter_shift_ctrl: RTL and testbench

Multi-cycle sequencer that performs 16-bit shifts and rotates of 0–15 positions by repeatedly applying a single one-position shift stage, one position per clock. It replaces a full log-depth barrel shifter where area matters more than latency. It sits beside the ALU as a start/done slave of the execute-stage control FSM.

---
 rtl/iter_shift_ctrl_pkg.sv | 23 ++
 rtl/iter_shift_ctrl_if.sv | 28 ++
 rtl/iter_shift_ctrl_shift1_stage.sv | 28 ++
 rtl/iter_shift_ctrl.sv | 75 +++++++
 tb/tb_iter_shift_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/iter_shift_ctrl_pkg.sv
// Shared definitions for the iterative shifter slice.
//   WIDTH / AMT_W : operand and shift-amount widths
//   OP_*          : operation codes carried on the op bus
//   state_e       : controller state encoding
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  // op[1] selects direction (0 = left, 1 = right), op[0] selects
  // logical (1) versus rotate (0).
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shift_ctrl_if.sv
// Start/done handshake and data bus between the execute-stage control FSM
// (master) and the iterative shifter (slave).
//   start, flush, op, amt, din : request side, driven by the master
//   ready, busy, done, dout    : status/result side, driven by the slave
interface iter_shift_ctrl_if;
  import shift_pkg::*;

  logic                    start;
  logic                    flush;
  logic [1:0]              op;
  logic [AMT_W-1:0]        amt;
  logic [WIDTH-1:0]        din;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic [WIDTH-1:0]        dout;

  modport master (
    output start, flush, op, amt, din,
    input  ready, busy, done, dout
  );

  modport slave (
    input  start, flush, op, amt, din,
    output ready, busy, done, dout
  );

endinterface

// File: rtl/iter_shift_ctrl_shift1_stage.sv
// Combinational one-position shift/rotate stage.
//   d   : operand
//   op  : ROL / SLL / ROR / SRL
//   q   : operand moved by exactly one position
module shift1_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  logic             fill_l;
  logic             fill_r;
  logic [WIDTH-1:0] lsh;
  logic [WIDTH-1:0] rsh;

  // The vacated end bit takes the wrapped bit for rotates, zero for logical shifts.
  assign fill_l = (op == OP_ROL) ? d[WIDTH-1] : 1'b0;
  assign fill_r = (op == OP_ROR) ? d[0]       : 1'b0;

  assign lsh = {d[WIDTH-2:0], fill_l};
  assign rsh = {fill_r, d[WIDTH-1:1]};

  // One 2:1 mux per bit, steered by the direction bit.
  assign q = op[1] ? rsh : lsh;

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative 16-bit shifter/rotator: one position per clock through a single
// shift1_stage, 0-15 positions per operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the start/done handshake (see iter_shift_ctrl_if)
// Latency from accepted start to done is amt+1 cycles; done is a one-cycle
// pulse and dout holds the result until the next accepted start.
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int AMT_W = shift_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  iter_shift_ctrl_if.slave  bus
);

  state_e           state;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       opr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_nxt;

  shift1_stage u_stage (
    .d  (data),
    .op (opr),
    .q  (data_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opr   <= OP_ROL;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            data  <= bus.din;
            opr   <= bus.op;
            cnt   <= bus.amt;
            state <= (bus.amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          // A flush abandons the operation but leaves the partial result visible.
          if (bus.flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            data <= data_nxt;
            cnt  <= cnt - 1'b1;
            if (cnt == AMT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded purely from the state register.
  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == SHIFT) || (state == DONE);
  assign bus.done  = (state == DONE);
  assign bus.dout  = data;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
module tb_iter_shift_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   done_cnt;

  iter_shift_ctrl_if bus();

  iter_shift_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result of shifting/rotating d by n positions, plain arithmetic.
  function automatic logic [15:0] model(input logic [1:0] op, input int n, input logic [15:0] d);
    logic [31:0] x;
    logic [31:0] r;
    x = {16'h0, d};
    case (op)
      2'b00:   r = (x << n) | (x >> (16 - n));
      2'b01:   r = x << n;
      2'b10:   r = (x >> n) | (x << (16 - n));
      default: r = x >> n;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  // Issue one operation and follow it to completion, checking every step.
  task automatic run_op(input logic [1:0] op, input int n, input logic [15:0] d, input string tag);
    int k;
    chk({tag, "_ready_pre"}, {31'h0, bus.ready}, 32'h1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.amt   = n[3:0];
    bus.din   = d;
    tick();
    bus.start = 1'b0;
    bus.din   = ~d;
    k = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      chk({tag, "_step"}, {16'h0, bus.dout}, {16'h0, model(op, k, d)});
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, n);
    chk({tag, "_dout"}, {16'h0, bus.dout}, {16'h0, model(op, n, d)});
    tick();
    chk({tag, "_ready_post"}, {30'h0, bus.ready, bus.busy}, 32'h2);
    chk({tag, "_hold"}, {16'h0, bus.dout}, {16'h0, model(op, n, d)});
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.amt   = 4'd0;
    bus.din   = 16'h0;
    #12;
    chk("rst_dout", {16'h0, bus.dout}, 32'h0);
    chk("rst_flags", {29'h0, bus.ready, bus.busy, bus.done}, 32'h4);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(2'b01, 0,  16'hA5A5, "sll0");
    run_op(2'b11, 4,  16'hF00F, "srl4");
    chk("srl4_const", {16'h0, bus.dout}, 32'h0F00);
    run_op(2'b00, 15, 16'h8001, "rol15");
    chk("rol15_const", {16'h0, bus.dout}, 32'hC000);
    run_op(2'b10, 1,  16'h0001, "ror1");
    chk("ror1_const", {16'h0, bus.dout}, 32'h8000);

    // start held every cycle while busy: only the first is taken
    done_cnt  = 0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.amt   = 4'd3;
    bus.din   = 16'h1234;
    tick();
    for (int i = 0; i < 10 && bus.done !== 1'b1; i++) begin
      bus.din = 16'($urandom);
      bus.amt = 4'($urandom);
      bus.op  = 2'($urandom);
      tick();
    end
    bus.start = 1'b0;
    chk("multi_dout", {16'h0, bus.dout}, 32'h91A0);
    tick();
    tick();
    chk("multi_done_cnt", done_cnt, 1);
    chk("multi_idle", {31'h0, bus.ready}, 32'h1);

    // flush in the second SHIFT cycle
    done_cnt  = 0;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.amt   = 4'd8;
    bus.din   = 16'h00F1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_idle", {29'h0, bus.ready, bus.busy, bus.done}, 32'h4);
    chk("flush_partial", {16'h0, bus.dout}, {16'h0, model(2'b00, 1, 16'h00F1)});
    for (int i = 0; i < 10; i++) tick();
    chk("flush_no_done", done_cnt, 0);
    chk("flush_hold", {16'h0, bus.dout}, {16'h0, model(2'b00, 1, 16'h00F1)});

    // asynchronous reset mid-shift
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.amt   = 4'd10;
    bus.din   = 16'hBEEF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("arst_busy_pre", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_dout", {16'h0, bus.dout}, 32'h0);
    chk("arst_flags", {29'h0, bus.ready, bus.busy, bus.done}, 32'h4);
    #1;
    rst_n = 1'b1;
    tick();

    // flush and start together in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b10;
    bus.amt   = 4'd2;
    bus.din   = 16'h5555;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("fs_busy", {31'h0, bus.busy}, 32'h0);
    chk("fs_dout", {16'h0, bus.dout}, 32'h0);
    run_op(2'b10, 2, 16'h5555, "after_fs");

    // randomized operations against the reference
    for (int i = 0; i < 25; i++) begin
      run_op(2'($urandom), int'($urandom_range(0, 15)), 16'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
